// File: rtl/rf_pkg.sv
// Shared register-file writeback constants and the arbitration priority type.
// Holds no logic; imported by the arbiter and the writeback top.
package rf_pkg;
   localparam int RF_AW       = 5;
   localparam int RF_DW       = 32;
   localparam int RF_NUM      = 2 ** RF_AW;
   localparam int RF_ZERO_IDX = 0;

   typedef enum logic {
      PRIO_REQ0 = 1'b0,
      PRIO_REQ1 = 1'b1
   } prio_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grants are combinational from the valids and the prio register.
// A lone valid always wins; prio flips only after a contended cycle; no grants while in reset.
module rr_arb2
   import rf_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic valid0,
   input  logic valid1,
   output logic grant0,
   output logic grant1
);

   prio_t prio;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio <= PRIO_REQ0;
      end else if (valid0 && valid1) begin
         prio <= (prio == PRIO_REQ0) ? PRIO_REQ1 : PRIO_REQ0;
      end
   end

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset) begin
         if (valid0 && (!valid1 || prio == PRIO_REQ0)) begin
            grant0 = 1'b1;
         end else if (valid1) begin
            grant1 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arb.sv
// Writeback arbiter for ALU/load results: registered regfile write port one cycle after transfer,
// pending-register scoreboard and bypass compare; unaccepted requesters simply hold (no buffering).
module rf_wb_arb
   import rf_pkg::*;
#(
   parameter int RF_AW = rf_pkg::RF_AW,
   parameter int RF_DW = rf_pkg::RF_DW
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req0_valid,
   output logic                    req0_ready,
   input  logic [RF_AW-1:0]        req0_addr,
   input  logic [RF_DW-1:0]        req0_data,
   input  logic                    req1_valid,
   output logic                    req1_ready,
   input  logic [RF_AW-1:0]        req1_addr,
   input  logic [RF_DW-1:0]        req1_data,
   input  logic                    issue_valid,
   input  logic [RF_AW-1:0]        issue_addr,
   output logic [(2**RF_AW)-1:0]   busy,
   output logic                    rf_we,
   output logic [RF_AW-1:0]        rf_waddr,
   output logic [RF_DW-1:0]        rf_wdata,
   input  logic [RF_AW-1:0]        raddr1,
   input  logic [RF_AW-1:0]        raddr2,
   output logic                    fwd1_hit,
   output logic                    fwd2_hit,
   output logic [RF_DW-1:0]        fwd_data
);

   localparam int               RF_NUM   = 2 ** RF_AW;
   localparam logic [RF_AW-1:0] ZERO_REG = RF_AW'(RF_ZERO_IDX);

   logic              gnt0;
   logic              gnt1;
   logic              xfer;
   logic [RF_AW-1:0]  sel_addr;
   logic [RF_DW-1:0]  sel_data;
   logic [RF_NUM-1:0] busy_q;
   logic [RF_NUM-1:0] busy_d;

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .grant0 (gnt0),
      .grant1 (gnt1)
   );

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // A grant is only ever raised for a valid requester, so a grant is a transfer.
   always_comb begin
      xfer     = gnt0 || gnt1;
      sel_addr = gnt1 ? req1_addr : req0_addr;
      sel_data = gnt1 ? req1_data : req0_data;
   end

   // r0 writes still complete the handshake and latch addr/data, but never raise rf_we.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= xfer && (sel_addr != ZERO_REG);
         if (xfer) begin
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
         end
      end
   end

   // Set is applied after clear so a same-cycle issue to the retiring register keeps it pending.
   always_comb begin
      busy_d = busy_q;
      if (xfer) begin
         busy_d[sel_addr] = 1'b0;
      end
      if (issue_valid && (issue_addr != ZERO_REG)) begin
         busy_d[issue_addr] = 1'b1;
      end
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign fwd1_hit = rf_we && (rf_waddr == raddr1) && (raddr1 != ZERO_REG);
   assign fwd2_hit = rf_we && (rf_waddr == raddr2) && (raddr2 != ZERO_REG);
   assign fwd_data = rf_wdata;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed literal checks, then randomized traffic against a behavioural model.
module tb_rf_wb_arb;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk;
   logic          reset;
   logic          req0_valid, req0_ready;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_data;
   logic          req1_valid, req1_ready;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_data;
   logic          issue_valid;
   logic [AW-1:0] issue_addr;
   logic [31:0]   busy;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [AW-1:0] raddr1, raddr2;
   logic          fwd1_hit, fwd2_hit;
   logic [DW-1:0] fwd_data;

   int n_checks = 0;
   int n_errors = 0;

   rf_wb_arb #(.RF_AW(AW), .RF_DW(DW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .busy(busy),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .raddr1(raddr1), .raddr2(raddr2),
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who the rules say wins, and what the write port / scoreboard hold.
   int            m_prio;
   bit [31:0]     m_busy;
   bit            m_we;
   bit [AW-1:0]   m_waddr;
   bit [DW-1:0]   m_wdata;
   bit            m_acc0, m_acc1;

   function automatic void exp_grant(output bit g0, output bit g1);
      g0 = 1'b0;
      g1 = 1'b0;
      if (!reset) begin
         if (req0_valid && req1_valid) begin
            if (m_prio == 0) g0 = 1'b1;
            else             g1 = 1'b1;
         end else begin
            g0 = req0_valid;
            g1 = req1_valid;
         end
      end
   endfunction

   always @(posedge clk or posedge reset) begin
      bit g0, g1;
      if (reset) begin
         m_prio = 0; m_busy = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
         m_acc0 = 1'b0; m_acc1 = 1'b0;
      end else begin
         exp_grant(g0, g1);
         m_acc0 = g0;
         m_acc1 = g1;
         m_we   = 1'b0;
         if (g0 || g1) begin
            m_waddr = g0 ? req0_addr : req1_addr;
            m_wdata = g0 ? req0_data : req1_data;
            m_we    = (m_waddr != 0);
            m_busy[m_waddr] = 1'b0;
         end
         if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
         if (req0_valid && req1_valid) m_prio = 1 - m_prio;
      end
   end

   // Compare process: one nanosecond before each rising edge, everything against the model.
   bit cmp_on = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (cmp_on) begin
            bit g0, g1, h1, h2;
            exp_grant(g0, g1);
            h1 = m_we && (m_waddr == raddr1) && (raddr1 != 0);
            h2 = m_we && (m_waddr == raddr2) && (raddr2 != 0);
            chk("m_req0_ready", 64'(req0_ready), 64'(g0));
            chk("m_req1_ready", 64'(req1_ready), 64'(g1));
            chk("m_rf_we",      64'(rf_we),      64'(m_we));
            chk("m_rf_waddr",   64'(rf_waddr),   64'(m_waddr));
            chk("m_rf_wdata",   64'(rf_wdata),   64'(m_wdata));
            chk("m_busy",       64'(busy),       64'(m_busy));
            chk("m_fwd1_hit",   64'(fwd1_hit),   64'(h1));
            chk("m_fwd2_hit",   64'(fwd2_hit),   64'(h2));
            chk("m_fwd_data",   64'(fwd_data),   64'(m_wdata));
         end
      end
   end

   task automatic idle();
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      issue_valid = 1'b0; issue_addr = '0;
      raddr1 = '0; raddr2 = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      cmp_on = 1'b1;
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 5'h10;
      #1;
      chk("rst_ready", 64'({req0_ready, req1_ready}), 64'(0));
      chk("rst_we",    64'(rf_we), 64'(0));
      chk("rst_busy",  64'(busy), 64'(0));
      chk("rst_waddr", 64'(rf_waddr), 64'(0));

      // single requester, first cycle after reset
      @(negedge clk);
      reset = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'h10; req0_data = 32'h0000ffff;
      #1;
      chk("single_ready0", 64'(req0_ready), 64'(1));
      chk("single_ready1", 64'(req1_ready), 64'(0));
      tick();
      chk("single_we",    64'(rf_we), 64'(1));
      chk("single_waddr", 64'(rf_waddr), 64'(5'h10));
      chk("single_wdata", 64'(rf_wdata), 64'(32'h0000ffff));

      // contention straight out of reset: req0 first, then req1
      @(negedge clk);
      idle();
      reset = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'h11; req0_data = 32'h1111ffff;
      req1_valid = 1'b1; req1_addr = 5'h12; req1_data = 32'h2222ffff;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rr_c1_ready", 64'({req0_ready, req1_ready}), 64'(2'b10));
      tick();
      chk("rr_c1_waddr", 64'(rf_waddr), 64'(5'h11));
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      chk("rr_c2_ready", 64'({req0_ready, req1_ready}), 64'(2'b01));
      tick();
      chk("rr_c2_we",    64'(rf_we), 64'(1));
      chk("rr_c2_waddr", 64'(rf_waddr), 64'(5'h12));
      chk("rr_c2_wdata", 64'(rf_wdata), 64'(32'h2222ffff));
      @(negedge clk);
      idle();
      tick();
      chk("idle_we",    64'(rf_we), 64'(0));
      chk("idle_waddr", 64'(rf_waddr), 64'(5'h12));

      // scoreboard: set wins over same-cycle clear
      @(negedge clk);
      issue_valid = 1'b1; issue_addr = 5'h13;
      tick();
      chk("sb_set", 64'(busy[5'h13]), 64'(1));
      @(negedge clk);
      req1_valid = 1'b1; req1_addr = 5'h13; req1_data = 32'h3333ffff;
      tick();
      chk("sb_set_wins", 64'(busy[5'h13]), 64'(1));
      chk("sb_set_we",   64'(rf_we), 64'(1));
      @(negedge clk);
      issue_valid = 1'b0;
      tick();
      chk("sb_clear", 64'(busy[5'h13]), 64'(0));

      // r0: handshake, no write, no busy
      @(negedge clk);
      idle();
      req0_valid = 1'b1; req0_addr = 5'h00; req0_data = 32'hffffffff;
      issue_valid = 1'b1; issue_addr = 5'h00;
      #1;
      chk("r0_ready", 64'(req0_ready), 64'(1));
      tick();
      chk("r0_we",   64'(rf_we), 64'(0));
      chk("r0_busy", 64'(busy), 64'(0));

      // bypass
      @(negedge clk);
      idle();
      req0_valid = 1'b1; req0_addr = 5'h14; req0_data = 32'h4444ffff;
      tick();
      raddr1 = 5'h14; raddr2 = 5'h00;
      #1;
      chk("fwd1_hit",  64'(fwd1_hit), 64'(1));
      chk("fwd2_hit",  64'(fwd2_hit), 64'(0));
      chk("fwd_data",  64'(fwd_data), 64'(32'h4444ffff));
      @(negedge clk);
      idle();
      raddr1 = 5'h14;
      tick();
      chk("fwd1_nowe", 64'(fwd1_hit), 64'(0));

      // asynchronous reset while a write is on the port and busy is nonzero
      @(negedge clk);
      idle();
      issue_valid = 1'b1; issue_addr = 5'h15;
      req0_valid = 1'b1; req0_addr = 5'h15; req0_data = 32'h5555ffff;
      tick();
      chk("ar_pre_we",   64'(rf_we), 64'(1));
      chk("ar_pre_busy", 64'(busy[5'h15]), 64'(1));
      req1_valid = 1'b1; req1_addr = 5'h16; req1_data = 32'h6666ffff;
      raddr1 = 5'h15;
      #1;
      reset = 1'b1;
      #1;
      chk("ar_we",    64'(rf_we), 64'(0));
      chk("ar_waddr", 64'(rf_waddr), 64'(0));
      chk("ar_wdata", 64'(rf_wdata), 64'(0));
      chk("ar_busy",  64'(busy), 64'(0));
      chk("ar_fwd",   64'({fwd1_hit, fwd2_hit}), 64'(0));
      chk("ar_ready", 64'({req0_ready, req1_ready}), 64'(0));
      @(negedge clk);
      idle();
      reset = 1'b0;
      tick();
      chk("ar_post_we", 64'(rf_we), 64'(0));

      // randomized traffic; requesters hold until the model says they were accepted
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 199) == 0);
         if (!(req0_valid && !m_acc0)) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_addr  = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom);
            req0_data  = $urandom;
         end
         if (!(req1_valid && !m_acc1)) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_addr  = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom);
            req1_data  = $urandom;
         end
         issue_valid = ($urandom_range(0, 1) != 0);
         issue_addr  = ($urandom_range(0, 3) == 0) ? req0_addr : 5'($urandom);
         raddr1 = ($urandom_range(0, 1) != 0) ? m_waddr : 5'($urandom);
         raddr2 = ($urandom_range(0, 2) == 0) ? m_waddr : 5'($urandom);
      end

      @(negedge clk);
      idle();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      cmp_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_arb.md
RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 Parameter RF_AW, default 5, register address width.
REQ-002 Parameter RF_DW, default 32, register data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req0_ready  input / output  1 / 1  writeback handshake, requester 0 (ALU).
REQ-006 req0_addr / req0_data  input  RF_AW / RF_DW  destination register and write value, requester 0.
REQ-007 req1_valid, req1_ready, req1_addr, req1_data  same widths and meaning as REQ-005/006, requester 1 (load unit).
REQ-008 issue_valid / issue_addr  input  1 / RF_AW  marks a destination register as pending.
REQ-009 busy  output  2**RF_AW  per-register pending (scoreboard) vector.
REQ-010 rf_we / rf_waddr / rf_wdata  output  1 / RF_AW / RF_DW  registered drive of the regfile write port.
REQ-011 raddr1 / raddr2  input  RF_AW  regfile read addresses, observed for bypass.
REQ-012 fwd1_hit / fwd2_hit  output  1  in-flight write matches raddr1 / raddr2.
REQ-013 fwd_data  output  RF_DW  equals rf_wdata; bypass value.

Function
REQ-014 Transfer on reqN when reqN_valid && reqN_ready in the same cycle; at most one transfer per cycle.
REQ-015 Only one valid: that requester's ready = 1, other ready = 0.
REQ-016 Both valid: grant requester selected by 1-bit round-robin pointer prio; other ready = 0.
REQ-017 prio toggles only after a cycle with both valid; single-valid cycles leave prio unchanged.
REQ-018 Neither valid: both ready = 0, prio unchanged.
REQ-019 Ready is combinational from the valids and prio; it does not depend on ready.
REQ-020 Latency: transfer in cycle N -> rf_we = 1, rf_waddr/rf_wdata = accepted addr/data in cycle N+1; no transfer -> rf_we = 0 in cycle N+1, rf_waddr/rf_wdata hold.
REQ-021 Transfer with addr 0: handshake completes, rf_we stays 0 (r0 never written).
REQ-022 issue_valid with issue_addr != 0 sets busy[issue_addr] at the next edge; issue_addr 0 ignored; busy[0] constantly 0.
REQ-023 Transfer to addr A clears busy[A] at the next edge.
REQ-024 Same-cycle issue set and transfer clear on the same address: set wins, busy stays 1.
REQ-025 Issue to a register already busy: stays 1 (no counting).
REQ-026 fwdK_hit = rf_we && rf_waddr == raddrK && raddrK != 0, combinational.
REQ-027 A requester held off keeps its valid/addr/data stable until accepted; the block does not buffer unaccepted requests.

Reset
REQ-028 While reset = 1: rf_we = 0, rf_waddr = 0, rf_wdata = 0, busy = 0, prio = 0 (requester 0 first), both ready = 0, fwd hits = 0.
REQ-029 Reset asserted mid-transfer discards the in-flight write; no rf_we pulse follows deassertion.
REQ-030 First edge after deassertion behaves per Function with prio = 0.

Structure
REQ-031 Shared package rf_pkg holds RF_AW, RF_DW, RF_NUM (= 2**RF_AW) and the zero-register index constant.
REQ-032 Arbitration (REQ-015..019) is sub-module rr_arb2: two valids in, two grants out, registered prio inside.
REQ-033 Scoreboard, output register and bypass compare stay in rf_wb_arb.

Verification
REQ-034 After reset, req0 valid addr 0x10 data 0x0000ffff alone -> req0_ready = 1, next cycle rf_we = 1, rf_waddr = 0x10, rf_wdata = 0x0000ffff.
REQ-035 req0 (0x11, 0x1111ffff) and req1 (0x12, 0x2222ffff) held valid together from reset -> req0 granted cycle 1, req1 cycle 2; rf writes 0x11 then 0x12 on consecutive cycles.
REQ-036 issue 0x13, then req1 write 0x13 data 0x3333ffff with issue 0x13 in the same cycle -> busy[0x13] stays 1; a later write alone -> busy[0x13] = 0 next cycle.
REQ-037 req0 write addr 0 data 0xffffffff -> req0_ready = 1, rf_we stays 0; issue addr 0 -> busy = 0.
REQ-038 req0 write 0x14 data 0x4444ffff, raddr1 = 0x14, raddr2 = 0x0 in next cycle -> fwd1_hit = 1, fwd2_hit = 0, fwd_data = 0x4444ffff.
REQ-039 reset pulsed while rf_we = 1 and busy nonzero -> all outputs 0 immediately (asynchronously); no write after release.
